// File: rtl/npu_sequencer.sv
// npu_sequencer: drives one two-neuron pass of the NPU core, from operand
// streaming through MAC, reLU and PISO write-back to the FIFO read-out.
module npu_sequencer #(
    parameter int LEN_W  = 8,
    parameter int RD_LAT = 1
) (
    input  logic             CLKEXT,
    input  logic             RST,
    input  logic             START,
    input  logic [LEN_W-1:0] LEN,
    input  logic [1:0]       CFG_BYPASS,
    input  logic             CFG_COMP,
    input  logic             OP_VALID,
    output logic             OP_READY,
    input  logic [31:0]      OP_DATA,
    output logic [7:0]       DA,
    output logic [7:0]       DB,
    output logic [7:0]       DC,
    output logic [7:0]       DD,
    output logic [15:0]      CON_SIG,
    output logic [15:0]      SSFR,
    output logic             RD_EN,
    input  logic [7:0]       DATA_OUT,
    output logic [7:0]       RES_DATA,
    output logic             RES_VALID,
    output logic             RES_LAST,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);
    localparam int PH_W = $clog2(RD_LAT + 4);

    typedef enum logic [3:0] {IDLE, CLEAR, ACC, DRAIN, RELU, PLOAD, PWR, READ, RWAIT} state_t;

    state_t            state, nxt;
    logic [PH_W-1:0]   ph;
    logic [LEN_W-1:0]  cnt, len_q;
    logic [1:0]        byp_q, res_cnt;
    logic              comp_q, hs;
    logic [RD_LAT-1:0] rd_pipe;
    logic en_buf, clr_buf, en_mac, rst_mac, en_relu, shift_out, en_piso, clr_piso, wr_en;
    logic en_comp, rst_comp, rst_fifo;

    assign OP_READY = state == ACC;
    assign hs       = OP_VALID && OP_READY;
    assign CON_SIG  = {en_buf, clr_buf, en_mac, rst_mac, en_relu, shift_out, en_piso, clr_piso, wr_en, 7'd0};
    assign SSFR     = {3'b000, byp_q, en_comp, rst_comp, BUSY, rst_fifo, 7'd0};

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = (START && LEN != '0) ? CLEAR : IDLE;
            CLEAR:   nxt = ACC;
            ACC:     nxt = (hs && cnt == len_q - LEN_W'(1)) ? DRAIN : ACC;
            DRAIN:   nxt = (ph == PH_W'(1)) ? RELU : DRAIN;
            RELU:    nxt = PLOAD;
            PLOAD:   nxt = PWR;
            PWR:     nxt = (ph == PH_W'(3)) ? READ : PWR;
            READ:    nxt = (ph == PH_W'(3)) ? RWAIT : READ;
            RWAIT:   nxt = (ph == PH_W'(RD_LAT)) ? IDLE : RWAIT;
            default: nxt = IDLE;
        endcase
    end

    // Control outputs are decoded from the next state so they line up with the state they belong to.
    always_ff @(posedge CLKEXT) begin
        if (!RST) begin
            state <= IDLE;
            ph <= '0;
            cnt <= '0;
            len_q <= '0;
            byp_q <= '0;
            comp_q <= 1'b0;
            {DD, DC, DB, DA} <= '0;
            {en_buf, clr_buf, en_mac, rst_mac, en_relu, shift_out, en_piso, clr_piso, wr_en} <= '0;
            {en_comp, rst_comp, rst_fifo} <= '0;
            rd_pipe <= '0;
            res_cnt <= '0;
            {RD_EN, RES_DATA, RES_VALID, RES_LAST, BUSY, DONE, ERR} <= '0;
        end else begin
            state <= nxt;
            ph <= (nxt != state) ? '0 : ph + PH_W'(1);
            if (nxt == CLEAR) begin
                len_q <= LEN;
                byp_q <= CFG_BYPASS;
                comp_q <= CFG_COMP;
            end
            ERR <= state == IDLE && START && LEN == '0;
            cnt <= (nxt == CLEAR) ? '0 : cnt + LEN_W'(hs);
            if (hs) {DD, DC, DB, DA} <= OP_DATA;
            en_buf <= hs;
            en_mac <= en_buf;
            clr_buf <= nxt == CLEAR;
            rst_mac <= nxt == CLEAR;
            clr_piso <= nxt == CLEAR;
            rst_fifo <= nxt == CLEAR;
            rst_comp <= nxt == CLEAR && CFG_COMP;
            en_relu <= nxt == RELU;
            en_comp <= nxt == RELU && comp_q;
            en_piso <= nxt == PLOAD || nxt == PWR;
            shift_out <= nxt == PWR;
            wr_en <= nxt == PWR;
            RD_EN <= nxt == READ;
            BUSY <= nxt != IDLE;
            rd_pipe <= (rd_pipe << 1) | RD_LAT'(RD_EN);
            if (rd_pipe[RD_LAT-1]) begin
                RES_DATA <= DATA_OUT;
                res_cnt <= res_cnt + 2'd1;
            end
            RES_VALID <= rd_pipe[RD_LAT-1];
            RES_LAST <= rd_pipe[RD_LAT-1] && res_cnt == 2'd3;
            DONE <= rd_pipe[RD_LAT-1] && res_cnt == 2'd3;
        end
    end
endmodule

// File: doc/npu_sequencer.md
NPU_SEQUENCER -- requirements
Module: npu_sequencer

Interface
REQ-001 Parameter LEN_W, default 8: width of the accumulate-length field.
REQ-002 Parameter RD_LAT, default 1: core DATA_OUT latency after RD_EN, in cycles.
REQ-003 CLKEXT  in  1  single clock; all logic on the rising edge.
REQ-004 RST  in  1  synchronous, active-low reset.
REQ-005 START  in  1  one-cycle request to run one two-neuron pass.
REQ-006 LEN  in  LEN_W  number of operand beats to accumulate; sampled with START.
REQ-007 CFG_BYPASS  in  2  {reLU2, reLU1} bypass; sampled with START.
REQ-008 CFG_COMP  in  1  enables the comparator update; sampled with START.
REQ-009 OP_VALID / OP_READY  in / out  1 / 1  operand stream handshake.
REQ-010 OP_DATA  in  32  operand beat {DD, DC, DB, DA}.
REQ-011 DA, DB, DC, DD  out  8 each  core operand bytes.
REQ-012 CON_SIG, SSFR  out  16 each  core control words.
REQ-013 RD_EN  out  1  core FIFO read strobe.
REQ-014 DATA_OUT  in  8  core output byte.
REQ-015 RES_DATA / RES_VALID / RES_LAST  out  8 / 1 / 1  result byte stream; no backpressure.
REQ-016 BUSY / DONE / ERR  out  1 each  status: BUSY is a level; DONE and ERR are one-cycle pulses.

Function
REQ-017 CON_SIG bit map: [15] EN_BUF_IN, [14] CLR_BUF_IN, [13] EN_MAC, [12] RST_MAC, [11] EN_reLU, [10] SHIFT_OUT, [9] EN_PISO_OUT, [8] CLR_PISO_OUT, [7] WR_EN, [6:0] = 0.
REQ-018 SSFR bit map: [15:13] SEL_OUT = 000, [12:11] latched CFG_BYPASS, [10] EN_COMP, [9] RST_COMP, [8] EN_FIFO = BUSY, [7] RST_FIFO, [6:0] = 0.
REQ-019 All outputs are registered, except OP_READY, which is a decode of state.
REQ-020 States: IDLE, CLEAR, ACC, DRAIN, RELU, PLOAD, PWR, READ, RWAIT.
REQ-021 IDLE, START=1, LEN≠0: latch LEN and CFG_*, go to CLEAR. LEN=0: pulse ERR next cycle and stay in IDLE.
REQ-022 START is ignored in every state other than IDLE.
REQ-023 CLEAR, 1 cycle: CLR_BUF_IN=RST_MAC=CLR_PISO_OUT=RST_FIFO=1 and RST_COMP=CFG_COMP, then go to ACC.
REQ-024 ACC: OP_READY=1.
REQ-025 ACC handshake at cycle t: DA..DD=OP_DATA and EN_BUF_IN=1 at t+1; EN_MAC=1 at t+2.
REQ-026 ACC: cycles without a handshake produce EN_BUF_IN=0 and EN_MAC=0 at the corresponding slots (bubbles allowed).
REQ-027 ACC: the LEN-th handshake moves the state to DRAIN; OP_READY=0 from the next cycle.
REQ-028 DRAIN lasts 2 cycles, so the last EN_BUF_IN and EN_MAC issue, then go to RELU.
REQ-029 RELU, 1 cycle: EN_reLU=1, EN_COMP=CFG_COMP.
REQ-030 PLOAD, 1 cycle: EN_PISO_OUT=1, SHIFT_OUT=0 (parallel load).
REQ-031 PWR, 4 cycles: EN_PISO_OUT=1, SHIFT_OUT=1, WR_EN=1; bytes are written in order reLU1[7:0], reLU1[15:8], reLU2[7:0], reLU2[15:8].
REQ-032 READ, 4 cycles: RD_EN=1.
REQ-033 Capture: DATA_OUT is sampled RD_LAT cycles after each RD_EN cycle; RES_VALID=1 with RES_DATA on the following cycle (RD_LAT+1 after RD_EN).
REQ-034 RES_LAST=1 and DONE=1 coincide with the 4th RES_VALID.
REQ-035 RWAIT lasts RD_LAT+1 cycles, then go to IDLE.
REQ-036 BUSY=1 in every state other than IDLE.
REQ-037 The beat counter is LEN_W bits and counts handshakes only; it never wraps within a pass.

Reset
REQ-038 RST=0 sampled on a clock edge: state=IDLE; all outputs, counters and latched configuration are 0 on the following cycle.
REQ-039 Reset mid-pass aborts with no RES_VALID or DONE afterwards.
REQ-040 Reset mid-pass leaves the core to be cleared by the next CLEAR state.

Verification
REQ-041 Nominal pass: RST released, START with LEN=3, OP_VALID constantly 1 (START sampled at cycle 0) -> CLEAR at 1, handshakes at 2-4, EN_MAC at 4-6, EN_reLU at 7, PLOAD at 8, WR_EN at 9-12, RD_EN at 13-16, RES_VALID at 15-18, DONE/RES_LAST at 18, BUSY=0 at 19.
REQ-042 Bubbles: LEN=2, OP_VALID pattern 1,0,0,1 -> EN_BUF_IN pattern 1,0,0,1 and EN_MAC the same pattern one cycle later; exactly 2 EN_MAC pulses.
REQ-043 LEN=0 with START -> ERR pulse one cycle later; BUSY stays 0; CON_SIG=0.
REQ-044 START pulsed during PWR -> ignored; exactly one DONE; the next START is accepted only in IDLE.
REQ-045 RST=0 during READ -> next cycle state IDLE and all outputs 0; no further RES_VALID.
REQ-046 Data check: core model returns bytes 0x11, 0x22, 0x33, 0x44 -> RES_DATA 0x11, 0x22, 0x33, 0x44 in order, with RES_LAST only on 0x44; CFG_BYPASS=2'b10 appears on SSFR[12:11]=10 throughout BUSY.
